seven_seg_scan_driver: RTL

Parametrised successor to the team's fixed 4-digit seven-segment multiplexer. It scans NUM_DIGITS common-anode/cathode digits with a programmable brightness window, anti-ghost guard band, per-digit blank and blink, decimal points and selectable output polarity. Display content is written through a valid/ready shadow interface and applied only at frame boundaries, so the display never shows a partly updated frame. It sits between the display-content logic and the board's segment/digit pins.

---
 rtl/seven_seg_scan_driver.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver.
// Scans NUM_DIGITS digits one slot at a time, with a programmable on-window
// inside each slot, a leading guard band, per-digit blank/blink and decimal
// points. New content arrives through a single-entry shadow buffer and is
// applied only at a frame boundary, so a frame is never shown half-updated.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned REFRESH_BITS     = 8,
  parameter int unsigned GUARD            = 2,
  parameter int unsigned BLINK_BITS       = 6,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      update_valid,
  output logic                      update_ready,
  input  logic [NUM_DIGITS*7-1:0]   digit_data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic [REFRESH_BITS-1:0]   brightness,
  output logic [6:0]                segment,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     digit_enable,
  output logic                      frame_start
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REFRESH_BITS-1:0] GUARD_V  = REFRESH_BITS'(GUARD);

  // Idle (unlit / inactive) levels for each output group.
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] EN_OFF  = DIGIT_ACTIVE_LOW ? '1 : '0;

  // Scan state
  logic [REFRESH_BITS-1:0] refresh_ctr;
  logic [IDX_W-1:0]        digit_idx;
  logic [BLINK_BITS-1:0]   frame_ctr;

  // Shadow content (written by the handshake) and active content (displayed)
  logic                             pending;
  logic [NUM_DIGITS-1:0][6:0]       data_sh;
  logic [NUM_DIGITS-1:0]            dp_sh;
  logic [NUM_DIGITS-1:0]            blank_sh;
  logic [NUM_DIGITS-1:0]            blink_sh;
  logic [REFRESH_BITS-1:0]          bright_sh;
  logic [NUM_DIGITS-1:0][6:0]       data_act;
  logic [NUM_DIGITS-1:0]            dp_act;
  logic [NUM_DIGITS-1:0]            blank_act;
  logic [NUM_DIGITS-1:0]            blink_act;
  logic [REFRESH_BITS-1:0]          bright_act;

  // Decode of the current scan position
  logic                  slot_end;
  logic                  frame_end;
  logic                  in_window;
  logic                  digit_dark;
  logic                  lit;
  logic [6:0]            cur_seg;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] onehot;

  assign update_ready = ~pending;

  // Slot/frame boundary detection and lit decision for the current digit.
  always_comb begin
    slot_end   = (refresh_ctr == '1);
    frame_end  = slot_end && (digit_idx == LAST_IDX);
    in_window  = (refresh_ctr >= GUARD_V) && (refresh_ctr < bright_act);
    digit_dark = blank_act[digit_idx] ||
                 (blink_act[digit_idx] && frame_ctr[BLINK_BITS-1]);
    lit        = in_window && !digit_dark;
    cur_seg    = data_act[digit_idx];
    cur_dp     = dp_act[digit_idx];
    onehot     = NUM_DIGITS'(1) << digit_idx;
  end

  // Slot counter, digit index and frame counter; all wrap freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_ctr <= '0;
      digit_idx   <= '0;
      frame_ctr   <= '0;
    end else begin
      refresh_ctr <= refresh_ctr + 1'b1;
      if (slot_end) begin
        if (digit_idx == LAST_IDX) begin
          digit_idx <= '0;
          frame_ctr <= frame_ctr + 1'b1;
        end else begin
          digit_idx <= digit_idx + 1'b1;
        end
      end
    end
  end

  // Shadow capture on valid & ready, shadow-to-active transfer at frame end.
  // A pending entry blocks capture, so capture and apply are exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= 1'b0;
      data_sh    <= '0;
      dp_sh      <= '0;
      blank_sh   <= '0;
      blink_sh   <= '0;
      bright_sh  <= '0;
      data_act   <= '0;
      dp_act     <= '0;
      blank_act  <= '0;
      blink_act  <= '0;
      bright_act <= '0;
    end else if (pending) begin
      if (frame_end) begin
        data_act   <= data_sh;
        dp_act     <= dp_sh;
        blank_act  <= blank_sh;
        blink_act  <= blink_sh;
        bright_act <= bright_sh;
        pending    <= 1'b0;
      end
    end else if (update_valid) begin
      data_sh   <= digit_data;
      dp_sh     <= dp_in;
      blank_sh  <= blank_mask;
      blink_sh  <= blink_mask;
      bright_sh <= brightness;
      pending   <= 1'b1;
    end
  end

  // Registered pin drive, one clock behind the scan state it reflects.
  always_ff @(posedge clk) begin
    if (reset) begin
      segment      <= SEG_OFF;
      dp_out       <= DP_OFF;
      digit_enable <= EN_OFF;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (lit) begin
        segment      <= cur_seg ^ SEG_OFF;
        dp_out       <= cur_dp ^ DP_OFF;
        digit_enable <= onehot ^ EN_OFF;
      end else begin
        segment      <= SEG_OFF;
        dp_out       <= DP_OFF;
        digit_enable <= EN_OFF;
      end
    end
  end

endmodule
